// File: rtl/popcount_sequencer.sv
// popcount_sequencer: multi-cycle population count that time-shares one 15:4 counter over 15-bit slices.
// Optional build macro POPCOUNT_EARLY_EXIT_EN: finish as soon as the remaining slices are all zero.

module counter15 (
   input  logic [14:0] bits_in,
   output logic [3:0]  count
);

   function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   logic [4:0] s1;
   logic [4:0] c1;
   logic [1:0] f5, f6, f7, f8, f9, f10;

   // Five full adders compress the inputs into weight-1 sums and weight-2 carries,
   // then the columns are reduced down to a single 4-bit count.
   always_comb begin
      s1 = '0;
      c1 = '0;
      for (int i = 0; i < 5; i++) begin
         {c1[i], s1[i]} = fa(bits_in[3*i], bits_in[3*i+1], bits_in[3*i+2]);
      end
      f5  = fa(s1[0], s1[1], s1[2]);
      f6  = fa(s1[3], s1[4], f5[0]);
      f7  = fa(c1[0], c1[1], c1[2]);
      f8  = fa(c1[3], c1[4], f5[1]);
      f9  = fa(f7[0], f8[0], f6[1]);
      f10 = fa(f7[1], f8[1], f9[1]);
      count = {f10[1], f10[0], f9[0], f6[0]};
   end

endmodule

module popcount_sequencer #(
   parameter  int IN_WIDTH = 60,
   localparam int NSLICE   = (IN_WIDTH + 14) / 15,
   localparam int CW       = $clog2(IN_WIDTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CW-1:0]       out_count,
   output logic                busy
);

   localparam int PADW = NSLICE * 15;
   localparam int IW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int SW   = (CW > 4) ? CW : 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [PADW-1:0] sr_q, sr_d;
   logic [CW-1:0]   acc_q, acc_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [3:0]      slice_cnt;
   logic [PADW-1:0] sr_shifted;
   logic [SW-1:0]   acc_sum;
   logic            last_slice;

   counter15 u_counter15 (
      .bits_in (sr_q[14:0]),
      .count   (slice_cnt)
   );

   always_comb begin
      sr_shifted = sr_q >> 15;
      // Sum is formed at least 4 bits wide; the total never exceeds IN_WIDTH, so narrowing to CW is lossless.
      acc_sum    = SW'(acc_q) + SW'(slice_cnt);
`ifdef POPCOUNT_EARLY_EXIT_EN
      last_slice = (sr_shifted == '0) || (idx_q == IW'(NSLICE - 1));
`else
      last_slice = (idx_q == IW'(NSLICE - 1));
`endif

      state_d   = state_q;
      sr_d      = sr_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sr_d    = PADW'(in_data);
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            sr_d  = sr_shifted;
            acc_d = CW'(acc_sum);
            idx_d = idx_q + IW'(1);
            if (last_slice) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_count = acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer: behavioural popcount/latency model plus directed and random operations.
module tb_popcount_sequencer;

`ifdef POPCOUNT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [59:0] in_data;
   logic [5:0]  out_count;

   logic        in20_valid, in20_ready, out20_valid, out20_ready, busy20;
   logic [19:0] in20_data;
   logic [4:0]  out20_count;

   int errors = 0;
   int checks = 0;

   popcount_sequencer #(.IN_WIDTH(60)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
   );

   popcount_sequencer #(.IN_WIDTH(20)) dut20 (
      .clk(clk), .rst_n(rst_n), .in_valid(in20_valid), .in_ready(in20_ready), .in_data(in20_data),
      .out_valid(out20_valid), .out_ready(out20_ready), .out_count(out20_count), .busy(busy20)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int popc(input logic [59:0] d);
      int n = 0;
      for (int i = 0; i < 60; i++) n += int'(d[i]);
      return n;
   endfunction

   function automatic int exp_lat(input logic [59:0] d);
      int h = 0;
      logic [59:0] t;
      if (!EARLY) return 4;
      for (int s = 0; s < 4; s++) begin
         t = d >> (15 * s);
         if (t[14:0] != 15'd0) h = s;
      end
      return h + 1;
   endfunction

   // Reference model: an accepted operand is pending; its result is due e_lat edges after accept.
   int  cyc, acc_cyc, e_lat, e_cnt;
   bit  pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc  <= 0;
         pend <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (!pend && in_valid) begin
            pend    <= 1'b1;
            acc_cyc <= cyc;
            e_cnt   <= popc(in_data);
            e_lat   <= exp_lat(in_data);
         end else if (pend && (cyc - acc_cyc > e_lat) && out_ready) begin
            pend <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      bit done;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_out_count", out_count, 0);
      end else begin
         done = pend && (cyc - acc_cyc > e_lat);
         chk("out_valid", out_valid, done);
         chk("in_ready", in_ready, !pend);
         chk("busy", busy, pend && !done);
         if (done) chk("out_count", out_count, e_cnt);
      end
   end

   task automatic run_op(input logic [59:0] d, input int hold, output int lat, output int cnt);
      int n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("wait_in_ready_timeout", 0, 1);
      out_ready = (hold == 0);
      in_data   = d;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!out_valid) chk("wait_out_valid_timeout", 0, 1);
      cnt = int'(out_count);
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk); #1; end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, cnt, n;
      logic [63:0] r;
      logic [59:0] d, keep;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      in20_valid = 1'b0; in20_data = '0; out20_ready = 1'b1;

      #2 rst_n = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_count", out_count, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op({60{1'b1}}, 0, lat, cnt);
      chk("ones_count", cnt, 60);
      chk("ones_latency", lat, 4);
      chk("ready_after_handshake", in_ready, 1);

      run_op(60'h800000000000001, 0, lat, cnt);
      chk("bits0_59_count", cnt, 2);
      chk("bits0_59_latency", lat, 4);

      run_op(60'h7, 1, lat, cnt);
      chk("low3_count", cnt, 3);
      chk("low3_latency", lat, EARLY ? 1 : 4);

      run_op(60'h0, 0, lat, cnt);
      chk("zero_count", cnt, 0);
      chk("zero_latency", lat, EARLY ? 1 : 4);

      // Result held while a new operand waits at the input.
      out_ready = 1'b0;
      in_data = 60'h0F0F_0000_0000_0FF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = 60'h000_0000_0003_F00;
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("held_valid", out_valid, 1);
         chk("held_count", out_count, 16);
         chk("held_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_release", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("new_accept_busy", busy, 1);
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("new_operand_count", out_count, 6);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of an operation.
      in_data = {60{1'b1}};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrun_rst_busy", busy, 0);
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_out_valid", out_valid, 0);
      chk("midrun_rst_count", out_count, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; chk("no_stale_result", out_valid, 0); end
      run_op(60'h5, 0, lat, cnt);
      chk("after_reset_count", cnt, 2);

      for (int k = 0; k < 40; k++) begin
         r = {$urandom, $urandom};
         n = $urandom_range(0, 4);
         keep = (n == 4) ? {60{1'b1}} : ((60'd1 << (15 * n)) - 60'd1);
         d = r[59:0] & keep;
         n = $urandom_range(0, 3);
         run_op(d, n, lat, cnt);
         chk("rand_count", cnt, popc(d));
         chk("rand_latency", lat, exp_lat(d));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      // Narrow instance: 20-bit operand padded into two slices.
      in20_data = 20'hFFFFF;
      in20_valid = 1'b1;
      @(posedge clk); #1;
      in20_valid = 1'b0;
      n = 0;
      while (!out20_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("w20_ones_count", out20_count, 20);
      chk("w20_ones_latency", n, 2);
      @(posedge clk); #1;
      in20_data = 20'h80001;
      in20_valid = 1'b1;
      @(posedge clk); #1;
      in20_valid = 1'b0;
      n = 0;
      while (!out20_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("w20_ends_count", out20_count, 2);
      chk("w20_ends_latency", n, 2);
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
